// File: rtl/pipe_pulse_pkg.sv
// Shared types and sizing helpers for the pipe-pulse receiver.
package pipe_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } pp_state_e;

    localparam int WINDOW_DEFAULT = 16;

    // Bits needed for a gap counter that has to reach the value window.
    function automatic int gap_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/pipe_pulse_gap_timer.sv
// Idle-gap counter. It counts consecutive zero samples while a burst is being
// collected and flags the sample that completes the closing window.
module pipe_pulse_gap_timer
    import pipe_pulse_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic elapsed
);

    localparam int GAP_W = gap_width(WINDOW);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WINDOW - 1);

    logic [GAP_W-1:0] gap_q;

    // Gap counter: a pulse restarts the gap, each idle COLLECT sample adds one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q <= '0;
        end else if (clear) begin
            gap_q <= '0;
        end else if (enable) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    // High on the idle sample whose count brings the gap to WINDOW, so the
    // FSM can close the burst on that same edge.
    assign elapsed = enable && !clear && (gap_q == GAP_LAST);

endmodule

// File: rtl/pipe_pulse_receiver.sv
// Terminating end of a pipe-pulse chain: groups pulses into bursts closed by
// an idle window, hands each burst count out over valid/ready, and forwards
// the raw stream one cycle later.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no burst in progress, waiting for the first pulse
// COLLECT | counting pulses, gap timer watching for the closing window
// PRESENT | closed burst held on burst_count/burst_sat until accepted
module pipe_pulse_receiver
    import pipe_pulse_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int WINDOW    = WINDOW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pipe_in,
    output logic                 pipe_out,
    output logic                 burst_valid,
    input  logic                 burst_ready,
    output logic [CNT_WIDTH-1:0] burst_count,
    output logic                 burst_sat,
    output logic                 active,
    output logic                 overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    pp_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;
    logic [CNT_WIDTH-1:0] bcount_q, bcount_d;
    logic                 bsat_q, bsat_d;
    logic                 overrun_q, overrun_d;
    logic                 pipe_q;
    logic                 window_done;

    pipe_pulse_gap_timer #(
        .WINDOW (WINDOW)
    ) u_gap_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pipe_in),
        .enable  (state_q == COLLECT),
        .elapsed (window_done)
    );

    // Tap-through of the raw stream, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= 1'b0;
        end else begin
            pipe_q <= pipe_in;
        end
    end

    // FSM state, pulse counter and presented-burst registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            sat_q     <= 1'b0;
            bcount_q  <= '0;
            bsat_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            bcount_q  <= bcount_d;
            bsat_q    <= bsat_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-value logic; a pulse arriving on the accepting
    // edge opens the next burst instead of being dropped.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sat_d     = sat_q;
        bcount_d  = bcount_q;
        bsat_d    = bsat_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pipe_in) begin
                    state_d = COLLECT;
                    count_d = CNT_ONE;
                    sat_d   = 1'b0;
                end
            end
            COLLECT: begin
                if (pipe_in) begin
                    if (count_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (window_done) begin
                    state_d  = PRESENT;
                    bcount_d = count_q;
                    bsat_d   = sat_q;
                end
            end
            PRESENT: begin
                if (burst_ready) begin
                    if (pipe_in) begin
                        state_d = COLLECT;
                        count_d = CNT_ONE;
                        sat_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pipe_in) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pipe_out    = pipe_q;
    assign burst_valid = (state_q == PRESENT);
    assign active      = (state_q == COLLECT);
    assign burst_count = bcount_q;
    assign burst_sat   = bsat_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/pipe_pulse_receiver.md
# pipe_pulse_receiver

Terminating end of a pipe-pulse chain. Samples the single-bit pulse stream from the last pipe-pulse stage and groups pulses into bursts separated by an idle gap. Reports each burst's pulse count over a valid/ready handshake. Also forwards the stream one cycle later, so the receiver can sit mid-chain as a tap.

## Interface
Parameters:
- CNT_WIDTH, 8: width of the burst pulse counter and of burst_count.
- WINDOW, 16: number of consecutive idle (pipe_in=0) cycles that closes a burst; legal range 2..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pipe_in  input  1  pulse stream from upstream pipe stage, synchronous to clk.
- pipe_out  output  1  pipe_in registered once (tap-through to the next stage).
- burst_valid  output  1  a closed burst is presented.
- burst_ready  input  1  consumer accepts the burst when high with burst_valid.
- burst_count  output  CNT_WIDTH  pulses counted in presented burst; stable while burst_valid.
- burst_sat  output  1  burst_count saturated at 2^CNT_WIDTH-1; stable while burst_valid.
- active  output  1  high while a burst is being collected (state COLLECT).
- overrun  output  1  one-cycle strobe per pulse dropped while a burst is waiting for acceptance.

## Operation
- Reset (reset_n=0, asynchronous): state IDLE. pipe_out, burst_valid, burst_count, burst_sat, active and overrun are all 0. Internal counters are cleared.
- A pulse is any cycle with pipe_in=1 sampled at a clk edge. Consecutive high cycles count as separate pulses.
- FSM states: IDLE, COLLECT, PRESENT.
  - IDLE: pipe_in=1 → COLLECT with count=1, gap=0. Otherwise stay.
  - COLLECT: pipe_in=1 → count+1 (saturating; set sat on the increment that would wrap), gap=0. pipe_in=0 → gap+1. When gap reaches WINDOW (the WINDOW-th consecutive zero sample), go to PRESENT, load burst_count/burst_sat from count/sat, and assert burst_valid.
  - PRESENT: burst_valid=1, outputs held. A pulse here is dropped and overrun strobes for 1 cycle.
    - burst_valid & burst_ready with pipe_in=0 → IDLE.
    - burst_valid & burst_ready with pipe_in=1 → COLLECT with count=1. That pulse is not lost and overrun stays 0.
- burst_valid, once asserted, never drops without a handshake. The consumer may hold burst_ready high permanently.
- Saturation: count stops at 2^CNT_WIDTH-1 and burst_sat=1. sat clears on entry to COLLECT.
- pipe_out is independent of the FSM and of the handshake.

## Timing
- pipe_out: pipe_in delayed exactly 1 cycle. 0 out of reset.
- active: high starting the cycle after the first pulse edge. It stays high until the cycle the FSM enters PRESENT.
- burst_valid latency: the last pulse is sampled at edge t. Zeros are sampled at edges t+1..t+WINDOW. burst_valid is high from just after edge t+WINDOW. No combinational path exists from pipe_in to any output.
- Handshake acceptance takes effect at the edge where both signals are high. burst_valid is low in the next cycle unless a new burst closes, which needs at least WINDOW+1 further cycles.
- Minimum burst period: 1 pulse cycle + WINDOW idle cycles + 1 handshake cycle.
- overrun: registered. It is high in the cycle following the edge that sampled the dropped pulse.
- Reset asserted mid-COLLECT or mid-PRESENT: the burst is discarded and not reported after reset_n rises.
- Deassertion of reset_n is assumed synchronised externally; the first sampled edge after release may capture a pulse.

## Structure
- Shared package pipe_pulse_pkg:
  - enum type for the FSM states (IDLE, COLLECT, PRESENT);
  - constant for the default WINDOW;
  - function returning $clog2(WINDOW+1), used to size the gap counter.
- Natural sub-module: pipe_pulse_gap_timer.
  - Contains the idle-gap counter.
  - Inputs: clear on pulse, count enable while in COLLECT.
  - Output: a "window elapsed" flag when the count equals WINDOW.
- The FSM, the saturating pulse counter and the output registers stay in pipe_pulse_receiver.

## Test plan
All with WINDOW=4, CNT_WIDTH=4 unless stated.
- Single pulse sampled at edge 10, burst_ready=1 → burst_valid high after edge 14 for 1 cycle, burst_count=1, burst_sat=0, active high cycles 11–14.
- Pulses at edges 10, 12, 14 (one zero between each) → exactly one burst, count=3, valid after edge 18.
- Pulses at edges 10 and 15 (4 zeros between) → two bursts, each count=1. Pulses at 10 and 14 (3 zeros) → one burst, count=2.
- pipe_in held high for 20 edges → burst_count=15, burst_sat=1. Next single-pulse burst → count=1, sat=0.
- burst_ready=0 for 10 cycles after valid; pulse during the wait → overrun strobes once and burst_count unchanged. Release ready with pipe_in=1 on the same edge → next burst count=1, no overrun.
- reset_n pulsed low for 1 cycle after 2 pulses in COLLECT → all outputs 0 immediately, no burst_valid afterwards. pipe_out tracks pipe_in delayed 1 cycle throughout all scenarios.
